// File: rtl/fsm_pkg.sv
// Shared types and constants for the "010" serial frame generator.
// The frame pattern is stored MSB-first: bit 2 goes out first.
package fsm_pkg;

    typedef enum logic [2:0] {
        G_IDLE,
        G_B0,
        G_B1,
        G_B2,
        G_GAP,
        G_DONE
    } gen_state_e;

    localparam int         FRAME_LEN = 3;
    localparam logic [2:0] FRAME_PAT = 3'b010;

    // Serial level for a given position inside the frame.
    function automatic logic frame_bit(input logic [1:0] pos);
        logic bit_val;
        case (pos)
            2'd0:    bit_val = FRAME_PAT[2];
            2'd1:    bit_val = FRAME_PAT[1];
            2'd2:    bit_val = FRAME_PAT[0];
            default: bit_val = 1'b1;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/seq_010_gen.sv
// Serial "010" frame transmitter: on an accepted start it sends num_frames
// frames, each followed by GAP_BITS guard ones, then pulses done.
module seq_010_gen
    import fsm_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int GAP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_frames,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int GAP_W = 4;

    gen_state_e       state_reg;
    gen_state_e       state_next;
    logic [CNT_W-1:0] remaining_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             abort_reg;

    logic accept;
    logic gap_last;
    logic abort_seen;

    assign accept     = (state_reg == G_IDLE) && start;
    assign gap_last   = (gap_cnt_reg == GAP_W'(GAP_BITS - 1));
    // An abort raised in the final guard cycle still ends the job there.
    assign abort_seen = abort_reg || abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= G_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            G_IDLE: begin
                if (accept) begin
                    state_next = (num_frames == '0) ? G_DONE : G_B0;
                end
            end
            G_B0:   state_next = G_B1;
            G_B1:   state_next = G_B2;
            G_B2:   state_next = G_GAP;
            G_GAP: begin
                if (gap_last) begin
                    state_next = ((remaining_reg == '0) || abort_seen) ? G_DONE : G_B0;
                end
            end
            G_DONE: state_next = G_IDLE;
            default: state_next = G_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining_reg <= '0;
            frame_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
            abort_reg     <= 1'b0;
        end else begin
            if (accept) begin
                remaining_reg <= num_frames;
                frame_cnt_reg <= '0;
                abort_reg     <= 1'b0;
            end else if (busy && abort) begin
                abort_reg <= 1'b1;
            end

            if (state_reg == G_B2) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
                remaining_reg <= remaining_reg - 1'b1;
                gap_cnt_reg   <= '0;
            end else if (state_reg == G_GAP) begin
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
        end
    end

    // Moore outputs: a reset drops the line back to idle without a clock edge.
    always_comb begin
        x = 1'b1;
        case (state_reg)
            G_B0:    x = frame_bit(2'd0);
            G_B1:    x = frame_bit(2'd1);
            G_B2:    x = frame_bit(2'd2);
            default: x = 1'b1;
        endcase
    end

    assign ready     = (state_reg == G_IDLE);
    assign done      = (state_reg == G_DONE);
    assign busy      = (state_reg == G_B0) || (state_reg == G_B1) ||
                       (state_reg == G_B2) || (state_reg == G_GAP);
    assign frame_cnt = frame_cnt_reg;

endmodule
